// File: rtl/readout_pkg.sv
// Shared types and default widths for the data-memory readout block.
package readout_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } rd_state_t;

endpackage

// File: rtl/readout_fifo2.sv
// Two-entry FIFO that absorbs the one-cycle read latency of data memory.
// The entries carry the data byte together with its end-of-dump flag.
module readout_fifo2 #(
  parameter int W = 9
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         empty,
  output logic         full,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;

  // NOTE: every signal gets a default before any branch so no latch is inferred.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      // NOTE: the two entries are reset so the head reads as zero out of reset.
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/dmem_readout.sv
// Dumps a fixed window of data memory over a valid/ready byte stream once
// the core raises Done; one byte per cycle when the consumer never stalls.
module dmem_readout
  import readout_pkg::*;
#(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                COUNT     = 64
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Done,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              finished
);

  localparam logic [ADDR_W:0] COUNT_C  = (ADDR_W + 1)'(COUNT);
  localparam logic [ADDR_W:0] LAST_IDX = COUNT_C - (ADDR_W + 1)'(1);

  rd_state_t         state_q, state_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   popped_q, popped_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q;

  logic              fifo_empty, fifo_full;
  logic [1:0]        fifo_count;
  logic [DATA_W:0]   fifo_head;
  logic              start, pop, credit_ok;
  logic [2:0]        occupancy;

  readout_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .Clk       (Clk),
    .Reset     (Reset),
    .push      (inflight_q),
    .push_data ({inflight_last_q, mem_rdata}),
    .pop       (pop),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .head      (fifo_head)
  );

  assign start     = Done && !done_q;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  // A pop this cycle frees a slot in time for a read issued alongside it.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign credit_ok = (occupancy < (3'd2 + {2'b00, pop})) && !(fifo_full && !pop);

  always_comb begin
    state_d         = state_q;
    issued_d        = issued_q;
    popped_d        = popped_q;
    next_addr_d     = next_addr_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    mem_ren         = 1'b0;
    busy            = 1'b0;
    finished        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          issued_d    = '0;
          popped_d    = '0;
          next_addr_d = BASE_ADDR;
          state_d     = (COUNT_C == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if ((issued_q < COUNT_C) && credit_ok) begin
          mem_ren         = 1'b1;
          issued_d        = issued_q + 1'b1;
          next_addr_d     = next_addr_q + 1'b1;
          inflight_d      = 1'b1;
          inflight_last_d = (issued_q == LAST_IDX);
        end
        if (pop) begin
          popped_d = popped_q + 1'b1;
          if (popped_q == LAST_IDX) state_d = FIN;
        end
      end
      FIN: begin
        finished = 1'b1;
        if (!Done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q         <= IDLE;
      issued_q        <= '0;
      popped_q        <= '0;
      next_addr_q     <= BASE_ADDR;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      issued_q        <= issued_d;
      popped_q        <= popped_d;
      next_addr_q     <= next_addr_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= Done;
    end
  end

  assign mem_addr = next_addr_q;
  assign out_data = fifo_head[DATA_W-1:0];
  assign out_last = out_valid && fifo_head[DATA_W];

endmodule
